// File: rtl/processor_pkg.sv
// ============================================================================
// Module   : processor_pkg
// Purpose  : Opcodes, sequencer state encodings and PC-control codes shared
//            by the processor core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package processor_pkg;

    localparam int DEFAULT_ADDR_W = 10;

    localparam logic [4:0] OP_HALT = 5'b00101;
    localparam logic [4:0] OP_IN   = 5'b01100;

    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_WRITEBACK = 3'd3;
    localparam logic [2:0] ST_WAIT_IN   = 3'd4;
    localparam logic [2:0] ST_HALTED    = 3'd5;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_JUMP = 2'd2
    } pc_op_t;

endpackage

`default_nettype wire

// File: rtl/seq_pc_unit.sv
// ============================================================================
// Module   : seq_pc_unit
// Purpose  : Program-counter register with hold / increment / jump select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pc_unit
    import processor_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  pc_op_t            pc_op,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // Increment wraps naturally at 2^ADDR_W.
    always_comb begin
        w_pc_next = r_pc;
        case (pc_op)
            PC_INC:  w_pc_next = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            PC_JUMP: w_pc_next = jump_target;
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/instruction_sequencer.sv
// ============================================================================
// Module   : instruction_sequencer
// Purpose  : Multi-cycle fetch/decode/execute/writeback sequencer with halt
//            and input-wait stalls. Optional macro
//            INSTR_SEQUENCER_RETIRE_COUNT_EN adds a retired-instruction count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_sequencer
    import processor_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        opcode,
    input  logic              pc_selector,
    input  logic              register_write_enabled,
    input  logic              memory_write_enabled,
    input  logic              output_write_enabled,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              in_valid,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic              ir_load,
    output logic              reg_write_strobe,
    output logic              mem_write_strobe,
    output logic              out_write_strobe,
    output logic              in_ack,
    output logic              halted,
    output logic [2:0]        state
`ifdef INSTR_SEQUENCER_RETIRE_COUNT_EN
    ,
    output logic [31:0]       retired_count
`endif
);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    pc_op_t     w_pc_op;
    logic       w_ir_load;
    logic       w_reg_strobe;
    logic       w_mem_strobe;
    logic       w_out_strobe;
    logic       w_in_ack;

    always_comb begin
        w_next_state = ST_FETCH;
        w_pc_op      = PC_HOLD;
        w_ir_load    = 1'b0;
        w_reg_strobe = 1'b0;
        w_mem_strobe = 1'b0;
        w_out_strobe = 1'b0;
        w_in_ack     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_ir_load    = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                w_next_state = (opcode == OP_HALT) ? ST_HALTED : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                w_next_state = (opcode == OP_IN) ? ST_WAIT_IN : ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                w_reg_strobe = register_write_enabled;
                w_mem_strobe = memory_write_enabled;
                w_out_strobe = output_write_enabled;
                w_pc_op      = pc_selector ? PC_JUMP : PC_INC;
                w_next_state = ST_FETCH;
            end
            ST_WAIT_IN: begin
                w_next_state = ST_WAIT_IN;
                if (in_valid) begin
                    w_in_ack     = 1'b1;
                    w_reg_strobe = 1'b1;
                    w_pc_op      = PC_INC;
                    w_next_state = ST_FETCH;
                end
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
                if (resume) begin
                    w_pc_op      = PC_INC;
                    w_next_state = ST_FETCH;
                end
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    seq_pc_unit #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clock       (clock),
        .reset       (reset),
        .pc_op       (w_pc_op),
        .jump_target (jump_target),
        .pc          (pc)
    );

    // State is already FETCH while reset is high, so only ir_load needs masking.
    assign ir_load          = w_ir_load & ~reset;
    assign reg_write_strobe = w_reg_strobe;
    assign mem_write_strobe = w_mem_strobe;
    assign out_write_strobe = w_out_strobe;
    assign in_ack           = w_in_ack;
    assign halted           = (r_state == ST_HALTED);
    assign state            = r_state;

`ifdef INSTR_SEQUENCER_RETIRE_COUNT_EN
    logic [31:0] r_retired_count;
    logic        w_retire;

    assign w_retire = (r_state == ST_WRITEBACK)
                    | ((r_state == ST_WAIT_IN) & in_valid)
                    | ((r_state == ST_HALTED) & resume);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired_count <= 32'd0;
        end else if (w_retire) begin
            r_retired_count <= r_retired_count + 32'd1;
        end
    end

    assign retired_count = r_retired_count;
`endif

endmodule

`default_nettype wire
